axi4_lite_master_tmo: RTL and testbench
=======================================

// Module: axi4_lite_master_tmo
// PURPOSE
//  Parametrised AXI4-Lite master driven by the AMCI control interface; next generation of our AMCI master.
//  Adds per-request byte strobes and protection bits, done pulses, and a watchdog that aborts hung transactions.
//  Independent read and write engines, one outstanding transaction each.
//  Used by register-access sequencers that must not hang on an unresponsive slave.
// PARAMETERS
//  AXI_DATA_WIDTH  32    data width in bits; must be 32 or 64
//  AXI_ADDR_WIDTH  32    address width in bits
//  TIMEOUT_CYCLES  1024  watchdog limit in cycles per transaction; 0 disables the watchdog
// PORTS
//  clk           in   1    clock
//  resetn        in   1    asynchronous active-low reset
//  AMCI_WADDR    in   AW   write address, sampled with AMCI_WRITE
//  AMCI_WDATA    in   DW   write data, sampled with AMCI_WRITE
//  AMCI_WSTRB    in   DW/8 byte strobes, sampled with AMCI_WRITE
//  AMCI_WPROT    in   3    AWPROT value, sampled with AMCI_WRITE
//  AMCI_WRITE    in   1    start-write pulse
//  AMCI_WRESP    out  2    BRESP of last write; 2'b10 on timeout
//  AMCI_WTIMEOUT out  1    1 = last write aborted by the watchdog
//  AMCI_WDONE    out  1    1-cycle pulse when a write finishes
//  AMCI_WIDLE    out  1    ~AMCI_WRITE & write FSM idle
//  AMCI_RADDR    in   AW   read address, sampled with AMCI_READ
//  AMCI_RPROT    in   3    ARPROT value, sampled with AMCI_READ
//  AMCI_READ     in   1    start-read pulse
//  AMCI_RDATA    out  DW   RDATA of last read; 0 on timeout
//  AMCI_RRESP    out  2    RRESP of last read; 2'b10 on timeout
//  AMCI_RTIMEOUT out  1    1 = last read aborted by the watchdog
//  AMCI_RDONE    out  1    1-cycle pulse when a read finishes
//  AMCI_RIDLE    out  1    ~AMCI_READ & read FSM idle
//  AXI_AW*/W*/B*/AR*/R*    standard AXI4-Lite master channels (AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY,
//                          BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY)
// BEHAVIOUR
//  Reset (async on resetn low): all VALID/READY = 0, both FSMs IDLE, *DONE = 0, *TIMEOUT = 0, *RESP = 0, AMCI_RDATA = 0,
//   AXI_AWADDR/WDATA/ARADDR = 0, AXI_WSTRB = 0, AXI_AWPROT/ARPROT = 0, watchdog counters = 0.
//  Write FSM: W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
//   W_IDLE & AMCI_WRITE (edge N): latch addr/data/strb/prot; AWVALID = WVALID = BREADY = 1 from N+1; go W_XFER.
//   W_XFER: each VALID drops in the cycle after its own handshake; AW and W may complete in either order or together.
//   Leave for W_RESP once both are done; zero-wait slave reaches W_RESP at N+2.
//   W_RESP: on B handshake, latch BRESP, WTIMEOUT = 0, BREADY = 0, WDONE pulses next cycle, go W_IDLE.
//  Read FSM: R_IDLE -> R_XFER -> R_IDLE.
//   R_IDLE & AMCI_READ: latch addr/prot; ARVALID = RREADY = 1 from next cycle.
//   R_XFER: ARVALID drops after AR handshake.
//   R handshake ends the read: latch RDATA/RRESP, RTIMEOUT = 0, RREADY = 0, RDONE pulse; an R handshake in the same cycle
//   as the AR handshake is accepted.
//  AMCI_WRITE / AMCI_READ while the matching FSM is not idle: ignored; latched outputs unchanged.
//  Read and write engines run fully concurrently; neither stalls the other.
//  Watchdog: per-engine counter cleared on leaving IDLE, +1 per non-idle cycle.
//   When count reaches TIMEOUT_CYCLES-1 with no completing handshake: drop every VALID/READY of that engine, RESP = 2'b10,
//   TIMEOUT = 1, DONE pulse, return to IDLE. RDATA = 0 for a read.
//   A completing handshake in the expiry cycle wins; the normal result is reported.
//  Watchdog abort breaks AXI VALID-stability; accepted by design, since the slave is hung. A late BVALID/RVALID arriving
//   while idle is ignored because READY = 0.
//  TIMEOUT_CYCLES = 0: counters held at 0, no aborts.
//  Reset mid-transaction: everything returns to reset values immediately; no DONE pulse.
//  Counter width: $clog2(TIMEOUT_CYCLES+1); no wrap occurs because expiry returns the engine to IDLE.
// TESTING
//  T1 write A=0x10 D=0x12345678 STRB=4'hF; AWREADY 2 cycles before WREADY, BRESP=0 -> WDONE once, WRESP=0, WTIMEOUT=0
//  T2 write with AW and W ready in the first VALID cycle, BRESP=2'b10 -> AW/WVALID high for exactly 1 cycle, WRESP=2
//  T3 read A=0x20, slave RDATA=0xDEADBEEF RRESP=0 after 3 cycles -> AMCI_RDATA=0xDEADBEEF, RDONE pulse, RIDLE=1
//  T4 TIMEOUT_CYCLES=16, slave never asserts AWREADY -> VALIDs drop after the 16th busy cycle, WRESP=2, WTIMEOUT=1
//  T5 RVALID first asserted in the expiry cycle with RDATA=0xA5A5A5A5 -> RTIMEOUT=0, RDATA=0xA5A5A5A5
//  T6 resetn low mid-read plus a second AMCI_WRITE while busy -> reset values at once; the busy-time write is not issued

Source files
------------

// File: rtl/axi4_lite_master_tmo_if.sv
// AXI4-Lite bus bundle between the AMCI master and its slave.
// The master modport drives the request channels and the response READYs.
interface axi4_lite_master_tmo_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   // write address channel
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   // write data channel
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   // write response channel
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   // read address channel
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   // read data channel
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_master_tmo.sv
// AXI4-Lite master controlled by the AMCI start/done interface.
// Independent read and write engines, one outstanding transaction each,
// each guarded by a watchdog that aborts a transaction on a hung slave.
// AXI_DATA_WIDTH must be 32 or 64; the interface instance must use the same widths.
module axi4_lite_master_tmo #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        resetn,
   // AMCI write side
   input  logic [AXI_ADDR_WIDTH-1:0]   AMCI_WADDR,
   input  logic [AXI_DATA_WIDTH-1:0]   AMCI_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0] AMCI_WSTRB,
   input  logic [2:0]                  AMCI_WPROT,
   input  logic                        AMCI_WRITE,
   output logic [1:0]                  AMCI_WRESP,
   output logic                        AMCI_WTIMEOUT,
   output logic                        AMCI_WDONE,
   output logic                        AMCI_WIDLE,
   // AMCI read side
   input  logic [AXI_ADDR_WIDTH-1:0]   AMCI_RADDR,
   input  logic [2:0]                  AMCI_RPROT,
   input  logic                        AMCI_READ,
   output logic [AXI_DATA_WIDTH-1:0]   AMCI_RDATA,
   output logic [1:0]                  AMCI_RRESP,
   output logic                        AMCI_RTIMEOUT,
   output logic                        AMCI_RDONE,
   output logic                        AMCI_RIDLE,
   // AXI4-Lite bus
   axi4_lite_master_tmo_if.master      axi
);

   localparam int DW = AXI_DATA_WIDTH;
   localparam int AW = AXI_ADDR_WIDTH;
   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
   // keep at least one counter bit so a disabled watchdog still elaborates
   localparam int CW = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int LIMIT_I = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_XFER}         r_state_t;

   // ---------------- write engine ----------------
   w_state_t        w_state_reg, w_state_next;
   logic [AW-1:0]   awaddr_reg;
   logic [2:0]      awprot_reg;
   logic [DW-1:0]   wdata_reg;
   logic [DW/8-1:0] wstrb_reg;
   logic            aw_done_reg, w_done_reg;
   logic [CW-1:0]   w_cnt_reg;
   logic [1:0]      wresp_reg;
   logic            wtimeout_reg, wdone_reg;

   logic w_start, w_busy, aw_hs, w_hs, b_hs, w_expire, aw_all, w_all;

   assign w_start  = (w_state_reg == W_IDLE) & AMCI_WRITE;
   assign w_busy   = (w_state_reg != W_IDLE);
   assign aw_hs    = (w_state_reg == W_XFER) & ~aw_done_reg & axi.awready;
   assign w_hs     = (w_state_reg == W_XFER) & ~w_done_reg & axi.wready;
   assign b_hs     = (w_state_reg == W_RESP) & axi.bvalid;
   assign aw_all   = aw_done_reg | aw_hs;
   assign w_all    = w_done_reg | w_hs;
   // only the B handshake completes a write, so it alone can beat the watchdog
   assign w_expire = WDOG_EN & w_busy & (w_cnt_reg == LIMIT) & ~b_hs;

   // write state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) w_state_reg <= W_IDLE;
      else         w_state_reg <= w_state_next;
   end

   // write next-state: address and data may finish in any order before the response phase
   always_comb begin
      w_state_next = w_state_reg;
      unique case (w_state_reg)
         W_IDLE: if (AMCI_WRITE) w_state_next = W_XFER;
         W_XFER: begin
            if (w_expire)             w_state_next = W_IDLE;
            else if (aw_all && w_all) w_state_next = W_RESP;
         end
         W_RESP: if (b_hs || w_expire) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // write bus outputs: each VALID falls the cycle after its own handshake
   always_comb begin
      axi.awvalid = (w_state_reg == W_XFER) & ~aw_done_reg;
      axi.wvalid  = (w_state_reg == W_XFER) & ~w_done_reg;
      axi.bready  = w_busy;
   end

   // write request latch and per-channel completion flags
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         awaddr_reg  <= '0;
         awprot_reg  <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
      end else if (w_start) begin
         awaddr_reg  <= AMCI_WADDR;
         awprot_reg  <= AMCI_WPROT;
         wdata_reg   <= AMCI_WDATA;
         wstrb_reg   <= AMCI_WSTRB;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
      end else begin
         if (aw_hs) aw_done_reg <= 1'b1;
         if (w_hs)  w_done_reg  <= 1'b1;
      end
   end

   // write watchdog: zero while idle, counts busy cycles otherwise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                w_cnt_reg <= '0;
      else if (!WDOG_EN || !w_busy) w_cnt_reg <= '0;
      else                        w_cnt_reg <= w_cnt_reg + CW'(1);
   end

   // write result and done pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wresp_reg    <= '0;
         wtimeout_reg <= 1'b0;
         wdone_reg    <= 1'b0;
      end else begin
         wdone_reg <= 1'b0;
         if (b_hs) begin
            wresp_reg    <= axi.bresp;
            wtimeout_reg <= 1'b0;
            wdone_reg    <= 1'b1;
         end else if (w_expire) begin
            wresp_reg    <= RESP_SLVERR;
            wtimeout_reg <= 1'b1;
            wdone_reg    <= 1'b1;
         end
      end
   end

   assign axi.awaddr    = awaddr_reg;
   assign axi.awprot    = awprot_reg;
   assign axi.wdata     = wdata_reg;
   assign axi.wstrb     = wstrb_reg;
   assign AMCI_WRESP    = wresp_reg;
   assign AMCI_WTIMEOUT = wtimeout_reg;
   assign AMCI_WDONE    = wdone_reg;
   assign AMCI_WIDLE    = ~AMCI_WRITE & ~w_busy;

   // ---------------- read engine ----------------
   r_state_t        r_state_reg, r_state_next;
   logic [AW-1:0]   araddr_reg;
   logic [2:0]      arprot_reg;
   logic            ar_done_reg;
   logic [CW-1:0]   r_cnt_reg;
   logic [DW-1:0]   rdata_reg;
   logic [1:0]      rresp_reg;
   logic            rtimeout_reg, rdone_reg;

   logic r_start, r_busy, ar_hs, r_hs, r_expire;

   assign r_start  = (r_state_reg == R_IDLE) & AMCI_READ;
   assign r_busy   = (r_state_reg == R_XFER);
   assign ar_hs    = r_busy & ~ar_done_reg & axi.arready;
   // an R beat is taken even in the same cycle as the AR handshake
   assign r_hs     = r_busy & axi.rvalid;
   assign r_expire = WDOG_EN & r_busy & (r_cnt_reg == LIMIT) & ~r_hs;

   // read state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state_reg <= R_IDLE;
      else         r_state_reg <= r_state_next;
   end

   // read next-state: the R handshake or the watchdog ends the read
   always_comb begin
      r_state_next = r_state_reg;
      unique case (r_state_reg)
         R_IDLE: if (AMCI_READ) r_state_next = R_XFER;
         R_XFER: if (r_hs || r_expire) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // read bus outputs
   always_comb begin
      axi.arvalid = r_busy & ~ar_done_reg;
      axi.rready  = r_busy;
   end

   // read request latch and address-phase flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         araddr_reg  <= '0;
         arprot_reg  <= '0;
         ar_done_reg <= 1'b0;
      end else if (r_start) begin
         araddr_reg  <= AMCI_RADDR;
         arprot_reg  <= AMCI_RPROT;
         ar_done_reg <= 1'b0;
      end else if (ar_hs) begin
         ar_done_reg <= 1'b1;
      end
   end

   // read watchdog: zero while idle, counts busy cycles otherwise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                r_cnt_reg <= '0;
      else if (!WDOG_EN || !r_busy) r_cnt_reg <= '0;
      else                        r_cnt_reg <= r_cnt_reg + CW'(1);
   end

   // read result and done pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_reg    <= '0;
         rresp_reg    <= '0;
         rtimeout_reg <= 1'b0;
         rdone_reg    <= 1'b0;
      end else begin
         rdone_reg <= 1'b0;
         if (r_hs) begin
            rdata_reg    <= axi.rdata;
            rresp_reg    <= axi.rresp;
            rtimeout_reg <= 1'b0;
            rdone_reg    <= 1'b1;
         end else if (r_expire) begin
            rdata_reg    <= '0;
            rresp_reg    <= RESP_SLVERR;
            rtimeout_reg <= 1'b1;
            rdone_reg    <= 1'b1;
         end
      end
   end

   assign axi.araddr    = araddr_reg;
   assign axi.arprot    = arprot_reg;
   assign AMCI_RDATA    = rdata_reg;
   assign AMCI_RRESP    = rresp_reg;
   assign AMCI_RTIMEOUT = rtimeout_reg;
   assign AMCI_RDONE    = rdone_reg;
   assign AMCI_RIDLE    = ~AMCI_READ & ~r_busy;

endmodule

// File: tb/tb_axi4_lite_master_tmo.sv
// Directed bench for axi4_lite_master_tmo with a 16-cycle watchdog.
module tb_axi4_lite_master_tmo;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] amci_waddr, amci_wdata, amci_raddr;
   logic [3:0]  amci_wstrb;
   logic [2:0]  amci_wprot, amci_rprot;
   logic        amci_write, amci_read;
   logic [1:0]  amci_wresp, amci_rresp;
   logic        amci_wtimeout, amci_wdone, amci_widle;
   logic [31:0] amci_rdata;
   logic        amci_rtimeout, amci_rdone, amci_ridle;

   int checks   = 0;
   int failures = 0;

   axi4_lite_master_tmo_if #(.DW(32), .AW(32)) axi ();

   axi4_lite_master_tmo #(
      .AXI_DATA_WIDTH(32),
      .AXI_ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .AMCI_WADDR    (amci_waddr),
      .AMCI_WDATA    (amci_wdata),
      .AMCI_WSTRB    (amci_wstrb),
      .AMCI_WPROT    (amci_wprot),
      .AMCI_WRITE    (amci_write),
      .AMCI_WRESP    (amci_wresp),
      .AMCI_WTIMEOUT (amci_wtimeout),
      .AMCI_WDONE    (amci_wdone),
      .AMCI_WIDLE    (amci_widle),
      .AMCI_RADDR    (amci_raddr),
      .AMCI_RPROT    (amci_rprot),
      .AMCI_READ     (amci_read),
      .AMCI_RDATA    (amci_rdata),
      .AMCI_RRESP    (amci_rresp),
      .AMCI_RTIMEOUT (amci_rtimeout),
      .AMCI_RDONE    (amci_rdone),
      .AMCI_RIDLE    (amci_ridle),
      .axi           (axi.master)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetn      = 1'b0;
      amci_waddr  = '0; amci_wdata = '0; amci_wstrb = '0; amci_wprot = '0; amci_write = 1'b0;
      amci_raddr  = '0; amci_rprot = '0; amci_read = 1'b0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = '0; axi.rdata = '0;
      repeat (3) tick;

      // reset state
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wvalid",  axi.wvalid,  0);
      chk("rst_bready",  axi.bready,  0);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_rready",  axi.rready,  0);
      chk("rst_awaddr",  axi.awaddr,  0);
      chk("rst_wstrb",   axi.wstrb,   0);
      chk("rst_rdata",   amci_rdata,  0);
      chk("rst_wdone",   amci_wdone,  0);
      chk("rst_widle",   amci_widle,  1);
      chk("rst_ridle",   amci_ridle,  1);
      resetn = 1'b1;
      tick;

      // T1: AW accepted two cycles before W, BRESP OKAY
      amci_waddr = 32'h10; amci_wdata = 32'h1234_5678; amci_wstrb = 4'hF; amci_wprot = 3'd0;
      amci_write = 1'b1;
      #1 chk("t1_widle_start", amci_widle, 0);
      tick; amci_write = 1'b0;
      chk("t1_awvalid", axi.awvalid, 1);
      chk("t1_wvalid",  axi.wvalid,  1);
      chk("t1_bready",  axi.bready,  1);
      chk("t1_awaddr",  axi.awaddr,  32'h10);
      chk("t1_wdata",   axi.wdata,   32'h1234_5678);
      chk("t1_wstrb",   axi.wstrb,   4'hF);
      axi.awready = 1'b1;
      tick; axi.awready = 1'b0;
      chk("t1_awvalid_drop", axi.awvalid, 0);
      chk("t1_wvalid_hold",  axi.wvalid,  1);
      tick;
      axi.wready = 1'b1;
      tick; axi.wready = 1'b0;
      chk("t1_wvalid_drop", axi.wvalid, 0);
      chk("t1_bready_hold", axi.bready, 1);
      chk("t1_wdone_early", amci_wdone, 0);
      axi.bresp = 2'b00; axi.bvalid = 1'b1;
      tick; axi.bvalid = 1'b0;
      chk("t1_wdone",    amci_wdone,    1);
      chk("t1_wresp",    amci_wresp,    0);
      chk("t1_wtimeout", amci_wtimeout, 0);
      chk("t1_bready",   axi.bready,    0);
      chk("t1_widle",    amci_widle,    1);
      tick;
      chk("t1_wdone_once", amci_wdone, 0);

      // T2: AW and W ready in the first VALID cycle, BRESP SLVERR
      amci_waddr = 32'h14; amci_wdata = 32'hCAFE_F00D; amci_wstrb = 4'h3; amci_wprot = 3'd5;
      amci_write = 1'b1;
      tick; amci_write = 1'b0;
      axi.awready = 1'b1; axi.wready = 1'b1;
      chk("t2_awvalid", axi.awvalid, 1);
      chk("t2_wvalid",  axi.wvalid,  1);
      chk("t2_awprot",  axi.awprot,  3'd5);
      chk("t2_wstrb",   axi.wstrb,   4'h3);
      tick; axi.awready = 1'b0; axi.wready = 1'b0;
      chk("t2_awvalid_1cyc", axi.awvalid, 0);
      chk("t2_wvalid_1cyc",  axi.wvalid,  0);
      chk("t2_bready",       axi.bready,  1);
      axi.bresp = 2'b10; axi.bvalid = 1'b1;
      tick; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      chk("t2_wdone", amci_wdone, 1);
      chk("t2_wresp", amci_wresp, 2'b10);
      chk("t2_wtimeout", amci_wtimeout, 0);
      tick;

      // T3: read with data three cycles after the address handshake
      amci_raddr = 32'h20; amci_rprot = 3'd2; amci_read = 1'b1;
      #1 chk("t3_ridle_start", amci_ridle, 0);
      tick; amci_read = 1'b0;
      chk("t3_arvalid", axi.arvalid, 1);
      chk("t3_rready",  axi.rready,  1);
      chk("t3_araddr",  axi.araddr,  32'h20);
      chk("t3_arprot",  axi.arprot,  3'd2);
      axi.arready = 1'b1;
      tick; axi.arready = 1'b0;
      chk("t3_arvalid_drop", axi.arvalid, 0);
      chk("t3_rready_hold",  axi.rready,  1);
      tick; tick;
      axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b00; axi.rvalid = 1'b1;
      tick; axi.rvalid = 1'b0;
      chk("t3_rdone",    amci_rdone,    1);
      chk("t3_rdata",    amci_rdata,    32'hDEAD_BEEF);
      chk("t3_rresp",    amci_rresp,    0);
      chk("t3_rtimeout", amci_rtimeout, 0);
      chk("t3_ridle",    amci_ridle,    1);
      chk("t3_rready",   axi.rready,    0);
      tick;
      chk("t3_rdone_once", amci_rdone, 0);

      // T4: write with AWREADY never asserted aborts after 16 busy cycles
      amci_waddr = 32'h50; amci_wdata = 32'h5555_AAAA; amci_wstrb = 4'hF; amci_write = 1'b1;
      tick; amci_write = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("t4_awvalid_busy", axi.awvalid, 1);
         tick;
      end
      chk("t4_awvalid_c16", axi.awvalid, 1);
      chk("t4_wdone_c16",   amci_wdone,   0);
      tick;
      chk("t4_awvalid", axi.awvalid,   0);
      chk("t4_wvalid",  axi.wvalid,    0);
      chk("t4_bready",  axi.bready,    0);
      chk("t4_wdone",   amci_wdone,    1);
      chk("t4_wresp",   amci_wresp,    2'b10);
      chk("t4_wtimeout", amci_wtimeout, 1);
      chk("t4_widle",   amci_widle,    1);
      tick;

      // T4r: read with ARREADY never asserted aborts likewise
      amci_raddr = 32'h60; amci_read = 1'b1;
      tick; amci_read = 1'b0;
      repeat (15) tick;
      chk("t4r_rready_c16", axi.rready, 1);
      tick;
      chk("t4r_rdone",    amci_rdone,    1);
      chk("t4r_rtimeout", amci_rtimeout, 1);
      chk("t4r_rresp",    amci_rresp,    2'b10);
      chk("t4r_rdata",    amci_rdata,    0);
      chk("t4r_arvalid",  axi.arvalid,   0);
      chk("t4r_rready",   axi.rready,    0);
      tick;

      // T5: RVALID first seen in the expiry cycle wins over the watchdog
      amci_raddr = 32'h70; amci_read = 1'b1;
      tick; amci_read = 1'b0;
      axi.arready = 1'b1;
      tick; axi.arready = 1'b0;
      repeat (14) tick;
      chk("t5_rdone_c16", amci_rdone, 0);
      axi.rdata = 32'hA5A5_A5A5; axi.rresp = 2'b00; axi.rvalid = 1'b1;
      tick; axi.rvalid = 1'b0;
      chk("t5_rdone",    amci_rdone,    1);
      chk("t5_rtimeout", amci_rtimeout, 0);
      chk("t5_rdata",    amci_rdata,    32'hA5A5_A5A5);
      chk("t5_rresp",    amci_rresp,    0);
      tick;

      // T6: reset mid-transaction, plus a write request while the write engine is busy
      amci_waddr = 32'h40; amci_wdata = 32'h1111_1111; amci_write = 1'b1;
      amci_raddr = 32'h30; amci_read = 1'b1;
      tick; amci_write = 1'b0; amci_read = 1'b0;
      chk("t6_arvalid", axi.arvalid, 1);
      amci_waddr = 32'h44; amci_wdata = 32'h2222_2222; amci_write = 1'b1;
      tick; amci_write = 1'b0;
      chk("t6_awaddr_kept", axi.awaddr, 32'h40);
      chk("t6_wdata_kept",  axi.wdata,  32'h1111_1111);
      resetn = 1'b0;
      #1;
      chk("t6_arvalid_rst", axi.arvalid,   0);
      chk("t6_rready_rst",  axi.rready,    0);
      chk("t6_awvalid_rst", axi.awvalid,   0);
      chk("t6_awaddr_rst",  axi.awaddr,    0);
      chk("t6_wresp_rst",   amci_wresp,    0);
      chk("t6_wtmo_rst",    amci_wtimeout, 0);
      chk("t6_rdata_rst",   amci_rdata,    0);
      tick;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("t6_no_write", axi.awvalid, 0);
         chk("t6_no_wdone", amci_wdone,  0);
         chk("t6_no_rdone", amci_rdone,  0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
